// File: rtl/encoder_serializer_pkg.sv
// Shared types and sizing helpers for the multi-hot to index serializer.
// Optional popcount output is enabled by defining ENCODER_COUNT_EN.
package encoder_serializer_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  localparam int DEF_WIDTH = 8;

  function automatic int idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/encoder_serializer_if.sv
// Vector-in / index-out handshake bundle for encoder_serializer.
// The count signal exists only when ENCODER_COUNT_EN is defined.
interface encoder_serializer_if #(parameter int WIDTH = 8);
  import encoder_serializer_pkg::*;
  localparam int IDX_W = idx_w(WIDTH);

  logic             enable;
  logic [WIDTH-1:0] in;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
`ifdef ENCODER_COUNT_EN
  logic [IDX_W:0]   count;

  modport master (output enable, in, in_valid, out_ready,
                  input  in_ready, out, out_valid, out_last, count);
  modport slave  (input  enable, in, in_valid, out_ready,
                  output in_ready, out, out_valid, out_last, count);
`else
  modport master (output enable, in, in_valid, out_ready,
                  input  in_ready, out, out_valid, out_last);
  modport slave  (input  enable, in, in_valid, out_ready,
                  output in_ready, out, out_valid, out_last);
`endif
endinterface

// File: rtl/encoder_serializer_lsb_encoder.sv
// Combinational lowest-set-bit finder: index of the lowest 1 plus a flag
// saying that bit is the only one left in the vector.
module lsb_encoder
  import encoder_serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             one_left
);
  // Scan high to low so the last hit is the lowest set bit.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (vec[i]) idx = IDX_W'(i);
  end

  assign one_left = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);
endmodule

// File: rtl/encoder_serializer.sv
// Multi-hot vector in, one binary index per handshake out, lowest bit first.
// Define ENCODER_COUNT_EN to add the registered popcount output.
module encoder_serializer
  import encoder_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  encoder_serializer_if.slave bus
);
  state_t           state;
  logic [WIDTH-1:0] pending;
  logic [IDX_W-1:0] idx, out_q;
  logic             one_left, busy, accept, beat;

  lsb_encoder #(.WIDTH(WIDTH)) u_lsb (
    .vec      (pending),
    .idx      (idx),
    .one_left (one_left)
  );

  assign busy          = (state == ST_BUSY);
  assign bus.in_ready  = bus.enable & !busy;
  assign bus.out_valid = bus.enable & busy;
  // While idle the last emitted index stays visible.
  assign bus.out       = busy ? idx : out_q;
  assign bus.out_last  = busy & one_left;

  assign accept = bus.in_valid & bus.in_ready & (bus.in != '0);
  assign beat   = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      pending <= '0;
      out_q   <= '0;
    end else if (!busy) begin
      if (accept) begin
        pending <= bus.in;
        state   <= ST_BUSY;
      end
    end else if (beat) begin
      pending <= pending & ~(WIDTH'(1) << idx);
      out_q   <= idx;
      if (one_left) state <= ST_IDLE;
    end
  end

`ifdef ENCODER_COUNT_EN
  logic [IDX_W:0] pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++)
      pop = pop + (IDX_W + 1)'(bus.in[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         bus.count <= '0;
    else if (accept) bus.count <= pop;
  end
`endif
endmodule
